// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Two-requester arbiter in front of a shared combinational ALU.
//            A granted request's operands are latched, presented to the ALU
//            for one cycle, and the result is held in a response register
//            until the consumer accepts it.
//            Each operation takes at least three cycles:
//            IDLE (accept) -> EXEC (capture result) -> DONE (hand off).
// Ports    : clk, rst (async, active-low)
//            req0_*/req1_* : valid/ready handshake, operands a/b, opcode op
//            alu_a/alu_b/alu_op -> shared ALU, alu_y <- ALU result
//            rsp_valid/rsp_ready/rsp_id/rsp_data : response handshake
//            busy : not IDLE; done_cnt : completed responses (wraps)
// Config   : ALU_ARBITER_FIXED_PRIO_EN - when defined, requester 0 always
//            wins contention and the round-robin state is removed.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             grant;      // id of the requester that would win now
  logic             accept;     // a request is taken this cycle
  logic             any_valid;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [2:0]       op_code;
  logic             op_id;

  assign any_valid = req0_valid | req1_valid;

`ifdef ALU_ARBITER_FIXED_PRIO_EN
  // Requester 0 always has priority.
  always_comb begin
    grant = req0_valid ? 1'b0 : 1'b1;
  end
`else
  logic last_grant;

  // On contention the requester not served last wins; otherwise the sole
  // valid requester wins. With no valid, grant is a don't-care.
  always_comb begin
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else begin
      grant = req0_valid ? 1'b0 : 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b1;   // requester 0 wins the first contention
    end else if (accept) begin
      last_grant <= grant;
    end
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs. The rst term keeps ready low while
  // reset is held even though the state already reads IDLE.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (rst && any_valid) begin
          accept     = 1'b1;
          req0_ready = ~grant;
          req1_ready = grant;
          state_nxt  = EXEC;
        end
      end
      EXEC: begin
        state_nxt = DONE;
      end
      DONE: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand latch, response register and completion counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_a      <= '0;
      op_b      <= '0;
      op_code   <= '0;
      op_id     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
      done_cnt  <= '0;
    end else begin
      if (accept) begin
        op_a    <= grant ? req1_a  : req0_a;
        op_b    <= grant ? req1_b  : req0_b;
        op_code <= grant ? req1_op : req0_op;
        op_id   <= grant;
      end
      if (state == EXEC) begin
        rsp_data  <= alu_y;
        rsp_id    <= op_id;
        rsp_valid <= 1'b1;
      end
      if ((state == DONE) && rsp_ready) begin
        rsp_valid <= 1'b0;
        done_cnt  <= done_cnt + CNT_W'(1);
      end
    end
  end

  // The ALU only ever sees latched operands, so requester inputs may change
  // freely once accepted.
  assign alu_a  = op_a;
  assign alu_b  = op_b;
  assign alu_op = op_code;
  assign busy   = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Self-checking bench for alu_arbiter. Directed steps plus random
//            operations are checked against a transaction-level model
//            (winner choice, result = a + b, response count modulo 2^CNT_W).
// Config   : honours ALU_ARBITER_FIXED_PRIO_EN for expected grant order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
  localparam int WIDTH = 32;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0_valid = 1'b0;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a = '0;
  logic [WIDTH-1:0] req0_b = '0;
  logic [2:0]       req0_op = '0;
  logic             req1_valid = 1'b0;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a = '0;
  logic [WIDTH-1:0] req1_b = '0;
  logic [2:0]       req1_op = '0;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_y;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             busy;
  logic [CNT_W-1:0] done_cnt;

  alu_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_y      (alu_y),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .done_cnt   (done_cnt)
  );

  always #5 clk = ~clk;

  // Shared ALU used by the bench: plain addition
  assign alu_y = alu_a + alu_b;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit m_last;   // id granted most recently (1 after reset)
  int m_cnt;    // completed responses modulo 2^CNT_W

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit winner(input bit v0, input bit v1);
    if (v0 && v1) begin
`ifdef ALU_ARBITER_FIXED_PRIO_EN
      return 1'b0;
`else
      return (m_last == 1'b0) ? 1'b1 : 1'b0;
`endif
    end
    return v0 ? 1'b0 : 1'b1;
  endfunction

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic scramble;
    req0_valid = 1'($urandom);
    req1_valid = 1'($urandom);
    req0_a     = $urandom;
    req0_b     = $urandom;
    req0_op    = 3'($urandom);
    req1_a     = $urandom;
    req1_b     = $urandom;
    req1_op    = 3'($urandom);
  endtask

  task automatic do_reset;
    rst        = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_done_cnt", done_cnt, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    m_last = 1'b1;
    m_cnt  = 0;
    step;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst        = 1'b1;
  endtask

  // One complete operation. Called just after a clock edge while the DUT is
  // in IDLE. Optionally asserts reset while the operation is in EXEC.
  task automatic op(input bit v0, input bit v1,
                    input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] o0,
                    input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] o1,
                    input int hold, input bit rst_in_exec, output bit id);
    bit          w;
    logic [31:0] ea, eb, ey;
    logic [2:0]  eo;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = o0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = o1;
    rsp_ready  = 1'b0;
    #1;
    w  = winner(v0, v1);
    ea = w ? a1 : a0;
    eb = w ? b1 : b0;
    eo = w ? o1 : o0;
    ey = ea + eb;
    id = w;
    chk("idle_ready0", req0_ready, (v0 && !w) ? 1 : 0);
    chk("idle_ready1", req1_ready, (v1 && w) ? 1 : 0);
    chk("idle_busy", busy, 0);
    step;
    // EXEC: requester inputs and an early rsp_ready must have no effect
    scramble;
    rsp_ready = 1'($urandom);
    #1;
    chk("exec_ready0", req0_ready, 0);
    chk("exec_ready1", req1_ready, 0);
    chk("exec_busy", busy, 1);
    chk("exec_rsp_valid", rsp_valid, 0);
    chk("exec_alu_a", alu_a, ea);
    chk("exec_alu_b", alu_b, eb);
    chk("exec_alu_op", alu_op, eo);
    if (rst_in_exec) begin
      rst = 1'b0;
      #1;
      m_cnt  = 0;
      m_last = 1'b1;
      chk("midrst_busy", busy, 0);
      chk("midrst_rsp_valid", rsp_valid, 0);
      chk("midrst_ready0", req0_ready, 0);
      chk("midrst_ready1", req1_ready, 0);
      chk("midrst_done_cnt", done_cnt, 0);
      rsp_ready  = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      step;
      rst = 1'b1;
      return;
    end
    rsp_ready = 1'b0;
    step;
    // DONE: response presented and held under backpressure
    chk("done_rsp_valid", rsp_valid, 1);
    chk("done_rsp_data", rsp_data, ey);
    chk("done_rsp_id", rsp_id, w);
    chk("done_busy", busy, 1);
    for (int i = 0; i < hold; i++) begin
      step;
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_data", rsp_data, ey);
      chk("bp_rsp_id", rsp_id, w);
      chk("bp_ready0", req0_ready, 0);
      chk("bp_ready1", req1_ready, 0);
    end
    rsp_ready = 1'b1;
    step;
    rsp_ready  = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    m_cnt  = (m_cnt + 1) % (1 << CNT_W);
    m_last = w;
    chk("hs_rsp_valid", rsp_valid, 0);
    chk("hs_done_cnt", done_cnt, m_cnt);
    chk("hs_busy", busy, 0);
  endtask

  initial begin
    bit id;
    int seq[5];
    bit v0, v1;
    seq = '{1, 2, 3, 0, 1};

    #3;
    do_reset;

    // No request: stays idle
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("noreq_ready0", req0_ready, 0);
    chk("noreq_ready1", req1_ready, 0);
    step;
    chk("noreq_busy", busy, 0);

    // Single request from requester 0
    op(1, 0, 32'h1, 32'hFFFF_FFFE, 3'd2, 32'h0, 32'h0, 3'd0, 0, 0, id);
    chk("single_id", id, 0);
    chk("single_data", rsp_data, 32'hFFFF_FFFF);
    chk("single_cnt", done_cnt, 1);

    // Contention after reset, both held for four operations
    do_reset;
    op(1, 1, 32'd1, 32'd2, 3'd3, 32'd10, 32'd20, 3'd5, 0, 0, id);
    chk("contend1_id", id, 0);
    chk("contend1_data", rsp_data, 32'd3);
    op(1, 1, 32'd1, 32'd2, 3'd3, 32'd10, 32'd20, 3'd5, 0, 0, id);
`ifdef ALU_ARBITER_FIXED_PRIO_EN
    chk("contend2_id", id, 0);
    chk("contend2_data", rsp_data, 32'd3);
`else
    chk("contend2_id", id, 1);
    chk("contend2_data", rsp_data, 32'd30);
`endif
    op(1, 1, 32'd1, 32'd2, 3'd3, 32'd10, 32'd20, 3'd5, 0, 0, id);
    chk("contend3_id", id, 0);
    op(1, 1, 32'd1, 32'd2, 3'd3, 32'd10, 32'd20, 3'd5, 0, 0, id);
`ifdef ALU_ARBITER_FIXED_PRIO_EN
    chk("contend4_id", id, 0);
`else
    chk("contend4_id", id, 1);
`endif

    // Backpressure for five cycles in DONE
    op(0, 1, $urandom, $urandom, 3'd1, $urandom, $urandom, 3'd6, 5, 0, id);
    chk("bp_id", id, 1);

    // Reset in EXEC, then a normal operation
    op(1, 1, $urandom, $urandom, 3'd4, $urandom, $urandom, 3'd7, 0, 1, id);
    op(1, 0, 32'd7, 32'd8, 3'd0, 32'd0, 32'd0, 3'd0, 1, 0, id);
    chk("post_midrst_data", rsp_data, 32'd15);
    chk("post_midrst_cnt", done_cnt, 1);

    // Counter wrap: five operations
    do_reset;
    for (int i = 0; i < 5; i++) begin
      op(1'($urandom), 1'b1, $urandom, $urandom, 3'($urandom),
         $urandom, $urandom, 3'($urandom), 0, 0, id);
      chk("wrap_cnt", done_cnt, seq[i]);
    end

    // Random operations
    for (int i = 0; i < 20; i++) begin
      v0 = 1'($urandom);
      v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1'b1;
      op(v0, v1, $urandom, $urandom, 3'($urandom), $urandom, $urandom, 3'($urandom),
         int'($urandom_range(0, 3)), 0, id);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width.
REQ-002 Parameter: CNT_W, 16, completed-operation counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 req0_valid / req1_valid  input  1  requester n has an operation pending.
REQ-006 req0_ready / req1_ready  output  1  requester n's operation accepted this cycle.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands of requester n.
REQ-008 req0_op / req1_op  input  3  ALU opcode of requester n, passed through unmodified.
REQ-009 alu_a, alu_b  output  WIDTH  operands to the shared combinational ALU.
REQ-010 alu_op  output  3  opcode to the shared ALU.
REQ-011 alu_y  input  WIDTH  ALU result.
REQ-012 rsp_valid  output  1  result available.
REQ-013 rsp_ready  input  1  consumer accepts result.
REQ-014 rsp_id  output  1  requester owning the result (0 or 1).
REQ-015 rsp_data  output  WIDTH  captured ALU result.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 done_cnt  output  CNT_W  count of completed response handshakes.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, EXEC, DONE.
REQ-019 In IDLE, reqN_ready SHALL be high combinationally only for the granted requester, and only when that requester's valid is high.
REQ-020 In IDLE with any valid high, the block SHALL latch the winner's a, b, op and id, then move to EXEC; with no valid it SHALL stay in IDLE.
REQ-021 alu_a, alu_b, alu_op SHALL always be driven from the latched operand registers, never directly from requester inputs.
REQ-022 In EXEC, the block SHALL capture alu_y into rsp_data, set rsp_valid=1, and move to DONE.
REQ-023 In DONE, rsp_valid, rsp_data and rsp_id SHALL hold stable until rsp_ready is high; on that handshake edge rsp_valid SHALL clear, done_cnt SHALL increment, and the state SHALL return to IDLE.
REQ-024 Latency: for an accept at edge N, rsp_valid SHALL be high after edge N+1; maximum throughput SHALL be one operation per 3 cycles.
REQ-025 Arbitration with a single valid SHALL grant that requester.
REQ-026 Arbitration with both valid SHALL grant the requester not granted last (round-robin; last_grant register).
REQ-027 reqN_ready SHALL be low in EXEC and DONE; requester inputs changing during those states SHALL NOT affect the in-flight operation.
REQ-028 done_cnt SHALL wrap from all-ones to 0.
REQ-029 rsp_ready high outside DONE SHALL be ignored.

Reset
REQ-030 Asserting rst low SHALL immediately, without a clock edge, force: state=IDLE; rsp_valid=0; rsp_data=0; rsp_id=0; done_cnt=0; operand registers=0; last_grant=1, so requester 0 wins the first contention.
REQ-031 Reset asserted mid-operation, in EXEC or DONE, SHALL discard the operation with no response, and the counter SHALL NOT increment.
REQ-032 While rst is low, req0_ready, req1_ready and busy SHALL be 0.

Configuration
REQ-033 Macro ALU_ARBITER_FIXED_PRIO_EN: when defined, contention SHALL always grant requester 0 and last_grant SHALL be absent; when undefined, round-robin per REQ-026 applies.

Verification
Bench ALU model: alu_y = alu_a + alu_b.
REQ-034 Single request: req0 a=32'h01, b=32'hFFFFFFFE -> req0_ready for 1 cycle; rsp_valid 2 edges later; rsp_data=32'hFFFFFFFF, rsp_id=0; done_cnt=1.
REQ-035 Contention after reset: both valid, req0 a=1 b=2, req1 a=10 b=20, both held -> responses in order id0 (data 3), then id1 (data 30); without the macro, the third grant goes to req0.
REQ-036 Backpressure: rsp_ready held low 5 cycles in DONE -> rsp_valid/rsp_data stable all 5 cycles; no ready pulses; one response on release.
REQ-037 Mid-op reset: rst low in EXEC -> busy=0 and rsp_valid=0 at once; done_cnt=0; the next request completes normally.
REQ-038 Counter wrap with CNT_W=2: 5 completed operations -> done_cnt sequence 1,2,3,0,1.
REQ-039 Macro defined: both valid for 4 operations -> all 4 grants go to requester 0.
